// File: rtl/trng_pkg.sv
// Shared constants and width helpers for the SR-latch TRNG collector.
package trng_pkg;
  localparam int NUM_CH_DEF     = 4;
  localparam int OUT_W_DEF      = 8;
  localparam int SAMPLE_DIV_DEF = 4;
  localparam int REP_LIMIT_DEF  = 16;
  localparam int CNT_W          = $clog2(OUT_W_DEF + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int mod_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/trng_collector_if.sv
// Output-side bundle of the collector: packed word, valid/read pop and health flag.
interface trng_collector_if #(parameter int OUT_W = 8);
  logic [OUT_W-1:0] data_o;
  logic             valid_o;
  logic             rd_i;
  logic             health_fail_o;

  modport master (output data_o, output valid_o, output health_fail_o, input rd_i);
  modport slave  (input data_o, input valid_o, input health_fail_o, output rd_i);
endinterface

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs input bits, emits the first of a differing pair.
// Output is combinational on the second bit of a pair; pass-through when disabled.
module trng_vn_debias (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic bit_i,
  input  logic bit_vld_i,
  output logic bit_o,
  output logic bit_vld_o
);
  logic have_first;
  logic first_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (!en) begin
      have_first <= 1'b0;
    end else if (bit_vld_i) begin
      if (!have_first) begin
        first_bit  <= bit_i;
        have_first <= 1'b1;
      end else begin
        have_first <= 1'b0;
      end
    end
  end

  assign bit_o     = en ? first_bit : bit_i;
  assign bit_vld_o = bit_vld_i & (~en | (have_first & (first_bit ^ bit_i)));
endmodule

// File: rtl/trng_collector.sv
// Synchronises and XORs raw latch bits, samples on a strobe, health-tests, debiases
// and packs bits MSB-first into words behind a valid/read holding register.
module trng_collector
  import trng_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] raw_i,
  input  logic              test_mode,
  input  logic              test_bit_i,
  input  logic              debias_en,
  trng_collector_if.master  bus
);
  localparam int CW = cnt_width(OUT_W);
  localparam int DW = mod_width(SAMPLE_DIV);
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [NUM_CH-1:0] sync1, sync2;
  logic              raw_bit;
  logic [DW-1:0]     div_cnt;
  logic              div_last, strobe;
  logic              prev_bit, health_fail, fail_set;
  logic [RW-1:0]     run_cnt, run_next;
  logic              emit_bit, emit_vld;
  logic [OUT_W-1:0]  acc, data_q;
  logic [CW-1:0]     cnt;
  logic              valid_q, full, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
    end
  end

  assign raw_bit  = test_mode ? test_bit_i : ^sync2;
  assign div_last = (div_cnt == DW'(SAMPLE_DIV - 1));
  assign strobe   = ena & div_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (ena)
      div_cnt <= div_last ? '0 : div_cnt + DW'(1);
  end

  // Repetition count runs on the raw bit, ahead of debiasing.
  always_comb begin
    run_next = RW'(1);
    if (raw_bit == prev_bit)
      run_next = (run_cnt == RW'(REP_LIMIT)) ? run_cnt : run_cnt + RW'(1);
  end

  assign fail_set = strobe & (run_next == RW'(REP_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bit    <= 1'b0;
      run_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (strobe) begin
      prev_bit <= raw_bit;
      run_cnt  <= run_next;
      if (fail_set)
        health_fail <= 1'b1;
    end
  end

  trng_vn_debias u_debias (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (debias_en),
    .bit_i     (raw_bit),
    .bit_vld_i (strobe & ~health_fail),
    .bit_o     (emit_bit),
    .bit_vld_o (emit_vld)
  );

  assign full = (cnt == CW'(OUT_W));
  assign xfer = full & (~valid_q | bus.rd_i);

  // A failing source wipes everything on the tripping edge so no word leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (health_fail | fail_set) begin
      acc     <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= acc;
      valid_q <= 1'b1;
      cnt     <= emit_vld ? CW'(1) : '0;
      acc     <= emit_vld ? OUT_W'(emit_bit) : '0;
    end else begin
      if (emit_vld && !full) begin
        acc <= {acc[OUT_W-2:0], emit_bit};
        cnt <= cnt + CW'(1);
      end
      if (bus.rd_i && valid_q)
        valid_q <= 1'b0;
    end
  end

  assign bus.data_o        = data_q;
  assign bus.valid_o       = valid_q;
  assign bus.health_fail_o = health_fail;
endmodule

// File: tb/tb_trng_collector.sv
// Directed plus randomized bench for trng_collector against a queue-based reference model.
module tb_trng_collector;
  logic       clk = 1'b0;
  logic       rst_n, ena, test_mode, test_bit, debias_en, rd;
  logic [3:0] raw;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  trng_collector_if #(.OUT_W(8)) bus1 ();
  trng_collector_if #(.OUT_W(8)) bus4 ();
  assign bus1.rd_i = rd;
  assign bus4.rd_i = 1'b0;

  trng_collector #(.NUM_CH(4), .OUT_W(8), .SAMPLE_DIV(1), .REP_LIMIT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_i(raw), .test_mode(test_mode),
    .test_bit_i(test_bit), .debias_en(debias_en), .bus(bus1));

  trng_collector #(.NUM_CH(4), .OUT_W(8), .SAMPLE_DIV(4), .REP_LIMIT(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_i(raw), .test_mode(test_mode),
    .test_bit_i(test_bit), .debias_en(debias_en), .bus(bus4));

  // Reference model of dut1 (SAMPLE_DIV=1): raw history, pair buffer, word queue.
  bit [3:0] m_s1, m_s2;
  bit       m_prev, m_fail, m_valid;
  int       m_run;
  bit       m_pair[$];
  bit       m_word[$];
  bit [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_fail = 0; m_valid = 0; m_run = 0; m_data = 0;
    m_pair.delete();
    m_word.delete();
  endtask

  task automatic m_step(input bit r_n, input bit e, input bit [3:0] rw, input bit tm,
                        input bit tbit, input bit de, input bit rdq);
    bit rb, full, xfer, emit, eb, trip;
    if (!r_n) begin
      m_reset();
      return;
    end
    rb   = tm ? tbit : ^m_s2;
    m_s2 = m_s1;
    m_s1 = rw;
    full = (m_word.size() == 8);
    xfer = full && (!m_valid || rdq);
    emit = 0; eb = 0; trip = 0;
    if (!de) m_pair.delete();
    if (e) begin
      m_run  = (rb != m_prev) ? 1 : ((m_run < 16) ? m_run + 1 : 16);
      m_prev = rb;
      trip   = (m_run == 16);
      if (!m_fail) begin
        if (!de) begin
          emit = 1; eb = rb;
        end else if (m_pair.size() == 0) begin
          m_pair.push_back(rb);
        end else begin
          if (m_pair[0] != rb) begin emit = 1; eb = m_pair[0]; end
          m_pair.delete();
        end
      end
    end
    if (m_fail || trip) begin
      m_fail = 1; m_valid = 0; m_data = 0;
      m_word.delete();
    end else if (xfer) begin
      m_data = 0;
      foreach (m_word[i]) m_data = {m_data[6:0], m_word[i]};
      m_valid = 1;
      m_word.delete();
      if (emit) m_word.push_back(eb);
    end else begin
      if (emit && !full) m_word.push_back(eb);
      if (rdq && m_valid) m_valid = 0;
    end
  endtask

  task automatic tick();
    bit c_r, c_e, c_tm, c_tb, c_de, c_rd;
    bit [3:0] c_raw;
    c_r = rst_n; c_e = ena; c_tm = test_mode; c_tb = test_bit; c_de = debias_en;
    c_rd = rd; c_raw = raw;
    @(posedge clk);
    #1;
    m_step(c_r, c_e, c_raw, c_tm, c_tb, c_de, c_rd);
    chk("model_valid", bus1.valid_o, m_valid);
    chk("model_data", bus1.data_o, m_data);
    chk("model_fail", bus1.health_fail_o, m_fail);
  endtask

  task automatic send(input bit b);
    test_bit = b;
    tick();
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_valid1", bus1.valid_o, 0);
    chk("rst_fail1", bus1.health_fail_o, 0);
    chk("rst_data4", bus4.data_o, 0);
    chk("rst_valid4", bus4.valid_o, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [19:0] pairs;
    logic [23:0] three;
    logic [7:0]  exp6;
    bit          q6[$];
    int          en_cnt;

    // 1. reset with arbitrary inputs, then idle with ena=0
    rst_n = 0; ena = 1; raw = 4'($urandom); test_mode = 1; test_bit = 1; debias_en = 1; rd = 1;
    m_reset();
    #1;
    chk("t1_data", bus1.data_o, 0);
    chk("t1_valid", bus1.valid_o, 0);
    chk("t1_fail", bus1.health_fail_o, 0);
    tick();
    rst_n = 1; ena = 0; rd = 0; debias_en = 0; raw = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_idle_valid", bus1.valid_o, 0);
    end

    // 2. plain word 0xB2
    ena = 1;
    for (int i = 7; i >= 0; i--) send(((8'hB2 >> i) & 8'h1) != 0);
    chk("t2_not_yet", bus1.valid_o, 0);
    ena = 0;
    tick();
    chk("t2_valid", bus1.valid_o, 1);
    chk("t2_data", bus1.data_o, 8'hB2);
    repeat (3) tick();
    chk("t2_hold", bus1.valid_o, 1);
    rd = 1; tick(); rd = 0;
    chk("t2_read_valid", bus1.valid_o, 0);
    chk("t2_read_data", bus1.data_o, 8'hB2);

    // 3. debiased pairs giving 0xB2
    debias_en = 1; ena = 1;
    pairs = 20'b10011100101001011001;
    for (int i = 19; i >= 0; i--) send(pairs[i]);
    ena = 0;
    tick();
    chk("t3_valid", bus1.valid_o, 1);
    chk("t3_data", bus1.data_o, 8'hB2);
    rd = 1; tick(); rd = 0;
    chk("t3_read", bus1.valid_o, 0);
    debias_en = 0;

    // 4. back-pressure: third word dropped
    ena = 1;
    three = 24'hB24DFF;
    for (int i = 23; i >= 0; i--) send(three[i]);
    ena = 0;
    tick();
    chk("t4_hold_data", bus1.data_o, 8'hB2);
    chk("t4_hold_valid", bus1.valid_o, 1);
    rd = 1; tick(); rd = 0;
    chk("t4_second_data", bus1.data_o, 8'h4D);
    chk("t4_second_valid", bus1.valid_o, 1);
    rd = 1; tick(); rd = 0;
    chk("t4_empty", bus1.valid_o, 0);

    // random traffic through both raw and test paths
    for (int i = 0; i < 400; i++) begin
      ena       = ($urandom % 4) != 0;
      test_mode = ($urandom % 4) == 0;
      test_bit  = 1'($urandom);
      raw       = 4'($urandom);
      rd        = ($urandom % 3) == 0;
      if (i % 50 == 0) debias_en = 1'($urandom);
      tick();
    end
    rd = 0; debias_en = 0; test_mode = 1; raw = 0;

    // 5. health: 15-run passes, 16-run trips and sticks
    rst_pulse();
    ena = 1;
    for (int i = 0; i < 15; i++) send(1);
    chk("t5_run15", bus1.health_fail_o, 0);
    send(0);
    chk("t5_no_fail", bus1.health_fail_o, 0);
    chk("t5_words", bus1.data_o, 8'hFF);
    for (int i = 0; i < 15; i++) send(1);
    chk("t5_before_trip", bus1.health_fail_o, 0);
    send(1);
    chk("t5_trip", bus1.health_fail_o, 1);
    chk("t5_trip_valid", bus1.valid_o, 0);
    chk("t5_trip_data", bus1.data_o, 0);
    for (int i = 0; i < 12; i++) send(1'($urandom));
    chk("t5_sticky", bus1.health_fail_o, 1);
    chk("t5_no_words", bus1.valid_o, 0);
    rst_pulse();
    chk("t5_cleared", bus1.health_fail_o, 0);

    // 6. SAMPLE_DIV=4 with ena toggling, reset mid-word
    en_cnt = 0;
    for (int i = 0; i < 400 && q6.size() < 5; i++) begin
      ena = 1'($urandom); test_bit = 1'($urandom);
      if (ena) begin
        if (en_cnt % 4 == 3) q6.push_back(test_bit);
        en_cnt++;
      end
      tick();
    end
    chk("t6_first5", q6.size(), 5);
    rst_pulse();
    q6.delete();
    en_cnt = 0;
    for (int i = 0; i < 400 && q6.size() < 8; i++) begin
      ena = 1'($urandom); test_bit = 1'($urandom);
      if (ena) begin
        if (en_cnt % 4 == 3) q6.push_back(test_bit);
        en_cnt++;
      end
      tick();
      chk("t6_no_early_valid", bus4.valid_o, 0);
    end
    chk("t6_bits", q6.size(), 8);
    exp6 = 0;
    foreach (q6[i]) exp6 = {exp6[6:0], q6[i]};
    ena = 0;
    tick();
    chk("t6_valid", bus4.valid_o, 1);
    chk("t6_data", bus4.data_o, exp6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
